// File: rtl/framed_deserializer_pkg.sv
// rtl/framed_deserializer_pkg.sv - shared state encoding and width helper for the frame receiver
package framed_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1, so a value of 1 still gets a one-bit field
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/framed_deserializer_if.sv
// rtl/framed_deserializer_if.sv - completed-word valid/ready bus between receiver and consumer
interface framed_deserializer_if #(
    parameter int WORD_SIZE        = 8,
    parameter int WORD_COUNT_WIDTH = 5
);
    logic [WORD_SIZE-1:0]        word_data;
    logic                        word_valid;
    logic                        word_ready;
    logic [WORD_COUNT_WIDTH-1:0] word_index;
    logic                        word_last;

    modport master (
        output word_data,
        output word_valid,
        output word_index,
        output word_last,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        input  word_index,
        input  word_last,
        output word_ready
    );
endinterface

// File: rtl/framed_deserializer_word_shift_register.sv
// rtl/framed_deserializer_word_shift_register.sv - serial bit collector with selectable bit order
module word_shift_register
    import framed_deserializer_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 shift_en,
    input  logic                 clear,
    input  logic                 bit_in,
    output logic [WORD_SIZE-1:0] word,
    output logic                 word_complete
);
    localparam int CW = clog2(WORD_SIZE);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_SIZE - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [WORD_SIZE-1:0] shreg;
    logic [WORD_SIZE-1:0] next_word;
    logic [CW-1:0]        bit_count;

    // The completed word includes the bit being sampled this cycle
    assign next_word     = MSB_FIRST ? {shreg[WORD_SIZE-2:0], bit_in}
                                     : {bit_in, shreg[WORD_SIZE-1:1]};
    assign word          = next_word;
    assign word_complete = shift_en && (bit_count == LAST_BIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (clear) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (shift_en) begin
            shreg     <= next_word;
            bit_count <= word_complete ? '0 : bit_count + ONE;
        end
    end
endmodule

// File: rtl/framed_deserializer.sv
// rtl/framed_deserializer.sv - serial-to-parallel multi-word frame receiver with one-entry output register
module framed_deserializer
    import framed_deserializer_pkg::*;
#(
    parameter int   WORD_SIZE        = 8,
    parameter int   MAX_WORDS        = 16,
    parameter int   WORD_COUNT_WIDTH = clog2(MAX_WORDS + 1),
    parameter logic START_BIT        = 1'b0,
    parameter bit   MSB_FIRST        = 1'b0,
    parameter bit   START_PER_WORD   = 1'b0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [WORD_COUNT_WIDTH-1:0] frame_words,
    input  logic                        abort,
    input  logic                        data_in,
    framed_deserializer_if.master       word_bus,
    output logic                        frame_done,
    output logic                        overrun,
    output logic                        busy
);
    localparam logic [WORD_COUNT_WIDTH-1:0] MAX_LEN = WORD_COUNT_WIDTH'(MAX_WORDS);
    localparam logic [WORD_COUNT_WIDTH-1:0] ONE     = WORD_COUNT_WIDTH'(1);

    state_t                      state, state_next;
    logic [WORD_COUNT_WIDTH-1:0] frame_len, word_count;
    logic                        start_ok, last_word;
    logic                        shift_en, shift_clear, word_complete;
    logic [WORD_SIZE-1:0]        shift_word;
    logic [WORD_SIZE-1:0]        data_q;
    logic [WORD_COUNT_WIDTH-1:0] index_q;
    logic                        valid_q, last_q;

    assign start_ok  = start && (frame_words != '0) && (frame_words <= MAX_LEN);
    assign last_word = (word_count == frame_len - ONE);

    word_shift_register #(
        .WORD_SIZE (WORD_SIZE),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clock         (clock),
        .reset_n       (reset_n),
        .shift_en      (shift_en),
        .clear         (shift_clear),
        .bit_in        (data_in),
        .word          (shift_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_ok) state_next = HUNT;
            HUNT: begin
                if (abort)                     state_next = IDLE;
                else if (data_in == START_BIT) state_next = SHIFT;
            end
            SHIFT: begin
                if (abort)              state_next = IDLE;
                else if (word_complete) begin
                    if (last_word)           state_next = IDLE;
                    else if (START_PER_WORD) state_next = HUNT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Abort masks the shift enable, so a word finishing in the abort cycle is never offered
    always_comb begin
        busy        = (state != IDLE);
        shift_en    = (state == SHIFT) && !abort;
        shift_clear = (state != SHIFT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_len  <= '0;
            word_count <= '0;
            data_q     <= '0;
            index_q    <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE && start_ok) begin
                frame_len  <= frame_words;
                word_count <= '0;
                overrun    <= 1'b0;
            end
            if (word_complete) begin
                word_count <= word_count + ONE;
                frame_done <= last_word;
                if (!valid_q || word_bus.word_ready) begin
                    data_q  <= shift_word;
                    index_q <= word_count;
                    last_q  <= last_word;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && word_bus.word_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign word_bus.word_data  = data_q;
    assign word_bus.word_valid = valid_q;
    assign word_bus.word_index = index_q;
    assign word_bus.word_last  = last_q;
endmodule
